// File: rtl/key_event_if.sv
// Key-event bundle between the tick/level source and key_event_gen, including
// FSM debug visibility.
// en is a 1-clk tick qualifier with no backpressure; the event outputs are
// 1-clk pulses that the consumer must sample on every clock.
interface key_event_if #(
    parameter int CNT_WIDTH = 10
);
    logic                 en;
    logic                 level;
    logic                 repeat_en;
    logic                 short_press;
    logic                 long_press;
    logic                 repeat_pulse;
    logic                 held;
    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] cnt;

    modport master (
        output en, level, repeat_en,
        input  short_press, long_press, repeat_pulse, held, state, cnt
    );

    modport slave (
        input  en, level, repeat_en,
        output short_press, long_press, repeat_pulse, held, state, cnt
    );
endinterface

// File: rtl/key_event_gen.sv
// Classifies a debounced key level into short-press, long-press and
// auto-repeat pulses, timed in debouncer ticks.
module key_event_gen #(
    parameter int LONG_TICKS   = 600,
    parameter int REPEAT_TICKS = 150,
    parameter int CNT_WIDTH    = 10
) (
    input  logic        clk,
    input  logic        reset,
    key_event_if.slave  kif
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LONG_TERM   = CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_TERM = CNT_WIDTH'(REPEAT_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 short_q, short_d;
    logic                 long_q, long_d;
    logic                 rep_q, rep_d;
    logic                 held_q, held_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= held_d;
        end
    end

    // Release is tested before the terminal tick so it wins a same-clock race.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        held_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (kif.level) begin
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (!kif.level) begin
                    short_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (kif.en) begin
                    if (cnt_q == LONG_TERM) begin
                        long_d  = 1'b1;
                        held_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            HOLD: begin
                held_d = 1'b1;
                if (!kif.level) begin
                    held_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (kif.en) begin
                    if (cnt_q == REPEAT_TERM) begin
                        cnt_d = '0;
                        rep_d = kif.repeat_en;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign kif.short_press  = short_q;
    assign kif.long_press   = long_q;
    assign kif.repeat_pulse = rep_q;
    assign kif.held         = held_q;
    assign kif.state        = state_q;
    assign kif.cnt          = cnt_q;
endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with LONG_TICKS=4, REPEAT_TICKS=2 and a
// tick strobe every 4th clock.
module tb_key_event_gen;
    localparam int LT = 4;
    localparam int RT = 2;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;

    key_event_if #(.CNT_WIDTH(CW)) kif ();

    key_event_gen #(
        .LONG_TICKS(LT),
        .REPEAT_TICKS(RT),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kif(kif)
    );

    always #5 clk = ~clk;

    int pass_n = 0;
    int total_n = 0;
    int tick_no, short_n, long_n, rep_n, multi_n, long_at;
    logic held_at_long;
    logic [7:0] rep_q[$];
    logic [7:0] exp_q[$];

    task automatic clear_obs();
        tick_no = 0; short_n = 0; long_n = 0; rep_n = 0; long_at = -1;
        held_at_long = 1'b0;
        rep_q.delete();
        exp_q.delete();
    endtask

    // One clock: drive inputs, cross the edge, record what the outputs show.
    task automatic clk_step(input logic lvl, input logic e);
        kif.level = lvl;
        kif.en = e;
        @(posedge clk);
        #1;
        kif.en = 1'b0;
        if (e) tick_no++;
        if ((int'(kif.short_press) + int'(kif.long_press) + int'(kif.repeat_pulse)) > 1) multi_n++;
        if (kif.short_press === 1'b1) short_n++;
        if (kif.long_press === 1'b1) begin
            long_n++;
            long_at = tick_no;
            held_at_long = kif.held;
        end
        if (kif.repeat_pulse === 1'b1) begin
            rep_n++;
            rep_q.push_back(8'(tick_no));
        end
    endtask

    task automatic run_ticks(input int n, input logic lvl);
        for (int i = 0; i < n; i++) begin
            repeat (3) clk_step(lvl, 1'b0);
            clk_step(lvl, 1'b1);
        end
    endtask

    task automatic test_reset();
        kif.level = 1'b1; kif.en = 1'b0; kif.repeat_en = 1'b1;
        #12;
        total_n++; if (kif.short_press !== 1'b0) $display("FAIL rst_short: got %b expected 0", kif.short_press); else pass_n++;
        total_n++; if (kif.long_press !== 1'b0) $display("FAIL rst_long: got %b expected 0", kif.long_press); else pass_n++;
        total_n++; if (kif.repeat_pulse !== 1'b0) $display("FAIL rst_repeat: got %b expected 0", kif.repeat_pulse); else pass_n++;
        total_n++; if (kif.held !== 1'b0) $display("FAIL rst_held: got %b expected 0", kif.held); else pass_n++;
        total_n++; if (kif.state !== 2'd0) $display("FAIL rst_state: got %0d expected 0", kif.state); else pass_n++;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total_n++; if (kif.state !== 2'd1) $display("FAIL rst_to_press: got %0d expected 1", kif.state); else pass_n++;
        total_n++; if (kif.cnt !== 10'd0) $display("FAIL rst_cnt: got %0d expected 0", kif.cnt); else pass_n++;
        clk_step(1'b0, 1'b0);
        total_n++; if (kif.short_press !== 1'b1) $display("FAIL rst_release_short: got %b expected 1", kif.short_press); else pass_n++;
        repeat (3) clk_step(1'b0, 1'b0);
    endtask

    task automatic test_short();
        clear_obs();
        run_ticks(2, 1'b1);
        clk_step(1'b0, 1'b0);
        total_n++; if (kif.short_press !== 1'b1) $display("FAIL short_timing: got %b expected 1", kif.short_press); else pass_n++;
        repeat (4) clk_step(1'b0, 1'b0);
        total_n++; if (short_n !== 1) $display("FAIL short_count: got %0d expected 1", short_n); else pass_n++;
        total_n++; if (long_n !== 0) $display("FAIL short_no_long: got %0d expected 0", long_n); else pass_n++;
        total_n++; if (kif.state !== 2'd0) $display("FAIL short_idle: got %0d expected 0", kif.state); else pass_n++;
    endtask

    task automatic test_long_repeat(input logic ren);
        clear_obs();
        kif.repeat_en = ren;
        if (ren) begin
            exp_q.push_back(8'd6); exp_q.push_back(8'd8); exp_q.push_back(8'd10);
        end
        run_ticks(9, 1'b1);
        total_n++; if (long_n !== 1) $display("FAIL long_count(ren=%b): got %0d expected 1", ren, long_n); else pass_n++;
        total_n++; if (long_at !== LT) $display("FAIL long_tick(ren=%b): got %0d expected %0d", ren, long_at, LT); else pass_n++;
        total_n++; if (held_at_long !== 1'b1) $display("FAIL long_held(ren=%b): got %b expected 1", ren, held_at_long); else pass_n++;
        total_n++; if (kif.cnt !== 10'd1) $display("FAIL hold_cnt9(ren=%b): got %0d expected 1", ren, kif.cnt); else pass_n++;
        run_ticks(1, 1'b1);
        total_n++; if (kif.cnt !== 10'd0) $display("FAIL hold_cnt10(ren=%b): got %0d expected 0", ren, kif.cnt); else pass_n++;
        total_n++; if (kif.held !== 1'b1) $display("FAIL hold_level(ren=%b): got %b expected 1", ren, kif.held); else pass_n++;
        total_n++; if (rep_q.size() !== exp_q.size()) $display("FAIL repeat_count(ren=%b): got %0d expected %0d", ren, rep_q.size(), exp_q.size()); else pass_n++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rep_q.size()) begin
                total_n++; if (rep_q[i] !== exp_q[i]) $display("FAIL repeat_tick[%0d]: got %0d expected %0d", i, rep_q[i], exp_q[i]); else pass_n++;
            end
        end
        clk_step(1'b0, 1'b0);
        total_n++; if (kif.held !== 1'b0) $display("FAIL release_held(ren=%b): got %b expected 0", ren, kif.held); else pass_n++;
        total_n++; if ({kif.short_press, kif.long_press, kif.repeat_pulse} !== 3'b000) $display("FAIL release_pulse(ren=%b): got %b expected 000", ren, {kif.short_press, kif.long_press, kif.repeat_pulse}); else pass_n++;
        repeat (3) clk_step(1'b0, 1'b0);
        total_n++; if (short_n !== 0) $display("FAIL hold_no_short(ren=%b): got %0d expected 0", ren, short_n); else pass_n++;
        kif.repeat_en = 1'b1;
    endtask

    task automatic test_race();
        clear_obs();
        run_ticks(3, 1'b1);
        repeat (3) clk_step(1'b1, 1'b0);
        clk_step(1'b0, 1'b1);
        total_n++; if (kif.short_press !== 1'b1) $display("FAIL race_press_short: got %b expected 1", kif.short_press); else pass_n++;
        total_n++; if (kif.long_press !== 1'b0) $display("FAIL race_press_long: got %b expected 0", kif.long_press); else pass_n++;
        repeat (4) clk_step(1'b0, 1'b0);
        total_n++; if (long_n !== 0) $display("FAIL race_press_long_count: got %0d expected 0", long_n); else pass_n++;

        clear_obs();
        kif.repeat_en = 1'b1;
        run_ticks(5, 1'b1);
        total_n++; if (kif.held !== 1'b1) $display("FAIL race_hold_entered: got %b expected 1", kif.held); else pass_n++;
        repeat (3) clk_step(1'b1, 1'b0);
        clk_step(1'b0, 1'b1);
        total_n++; if (kif.repeat_pulse !== 1'b0) $display("FAIL race_hold_repeat: got %b expected 0", kif.repeat_pulse); else pass_n++;
        total_n++; if (kif.held !== 1'b0) $display("FAIL race_hold_held: got %b expected 0", kif.held); else pass_n++;
        repeat (4) clk_step(1'b0, 1'b0);
        total_n++; if (rep_n !== 0) $display("FAIL race_hold_rep_count: got %0d expected 0", rep_n); else pass_n++;
        total_n++; if (kif.state !== 2'd0) $display("FAIL race_hold_idle: got %0d expected 0", kif.state); else pass_n++;
    endtask

    task automatic test_reset_mid_hold();
        clear_obs();
        kif.repeat_en = 1'b1;
        run_ticks(6, 1'b1);
        repeat (3) clk_step(1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        total_n++; if (kif.held !== 1'b0) $display("FAIL midrst_held: got %b expected 0", kif.held); else pass_n++;
        total_n++; if ({kif.short_press, kif.long_press, kif.repeat_pulse} !== 3'b000) $display("FAIL midrst_pulses: got %b expected 000", {kif.short_press, kif.long_press, kif.repeat_pulse}); else pass_n++;
        total_n++; if (kif.cnt !== 10'd0) $display("FAIL midrst_cnt: got %0d expected 0", kif.cnt); else pass_n++;
        @(negedge clk);
        reset = 1'b1;
        clear_obs();
        run_ticks(4, 1'b1);
        total_n++; if (long_n !== 1) $display("FAIL midrst_long_count: got %0d expected 1", long_n); else pass_n++;
        total_n++; if (long_at !== LT) $display("FAIL midrst_long_tick: got %0d expected %0d", long_at, LT); else pass_n++;
        total_n++; if (short_n !== 0) $display("FAIL midrst_no_short: got %0d expected 0", short_n); else pass_n++;
        repeat (4) clk_step(1'b0, 1'b0);
    endtask

    initial begin
        multi_n = 0;
        clear_obs();
        test_reset();
        test_short();
        test_long_repeat(1'b1);
        test_long_repeat(1'b0);
        test_race();
        test_reset_mid_hold();
        total_n++; if (multi_n !== 0) $display("FAIL one_pulse_per_clk: got %0d clocks with overlap expected 0", multi_n); else pass_n++;
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
